patch_reassembler: RTL
======================

// Module: patch_reassembler
// PURPOSE
//  Inverse of the patchifier: receives one flattened patch as a serial pixel stream
//  (valid/ready), rebuilds the PATCH_SIZE x PATCH_SIZE 2D patch and holds it until consumed.
//  Sits on the output side of the vision pipeline, in front of any block that needs 2D
//  pixel layout, e.g. image write-back or visualisation. Uses the same IDLE/PROCESSING/DONE
//  state encoding and output_taken handoff as the patchifier.
// PARAMETERS
//  CHANNEL_SIZE       8                            bits per colour channel
//  NUM_CHANNELS       3                            channels per pixel (RGB)
//  PIXEL_WIDTH        CHANNEL_SIZE*NUM_CHANNELS    bits per pixel
//  PATCH_SIZE         16                           patch edge length, >=2
//  PATCH_VECTOR_SIZE  PATCH_SIZE*PATCH_SIZE        pixels per patch
//  CNT_W              $clog2(PATCH_VECTOR_SIZE+1)  width of the pixel counter
// PORTS
//  clk           in   1            clock; all logic on posedge
//  reset         in   1            synchronous, active-high
//  en            in   1            start capture of one patch; sampled in IDLE only
//  in_valid      in   1            in_pixel carries a valid pixel
//  in_pixel      in   PIXEL_WIDTH  next pixel of the flattened patch
//  in_ready      out  1            block accepts in_pixel this cycle
//  output_taken  in   1            consumer has taken patch_out; sampled in DONE only
//  state         out  2            00 IDLE, 01 PROCESSING, 10 DONE
//  out_valid     out  1            patch_out is complete and stable
//  pixel_count   out  CNT_W        pixels accepted for the current patch
//  patch_out     out  PIXEL_WIDTH x [PATCH_SIZE][PATCH_SIZE]   reassembled patch [row][col]
// BEHAVIOUR
//  Reset: clock clk; reset is synchronous, active-high.
//   - Reset values: state=IDLE, row=col=0, pixel_count=0, every patch_out element=0.
//   - Reset has priority over all other inputs, including in the middle of a capture.
//  Outputs: in_ready = (state==PROCESSING); out_valid = (state==DONE). Both are combinational
//   from the state register.
//  Accept: a pixel is accepted on a posedge where in_valid && in_ready.
//   - The accepted pixel is written to patch_out[row][col].
//   - pixel_count increments by 1.
//   - col increments; when col wraps from PATCH_SIZE-1 to 0, row increments.
//   - in_valid may stay low for any number of cycles; nothing changes while it is low.
//  FSM:
//   - IDLE -> PROCESSING when en=1. This takes one cycle, so the first pixel can be accepted
//     no earlier than the cycle after en.
//   - PROCESSING -> DONE on the posedge that accepts the pixel at index PATCH_VECTOR_SIZE-1.
//     out_valid is high in the following cycle.
//   - DONE -> IDLE when output_taken=1. On that same posedge, patch_out, pixel_count,
//     row and col clear to 0.
//  Ignored inputs:
//   - en while in PROCESSING or DONE.
//   - output_taken while in IDLE or PROCESSING.
//   - in_valid while in IDLE or DONE (in_ready is low, so no pixel is accepted).
//  Simultaneous events:
//   - en=1 together with output_taken=1 in DONE: the block goes to IDLE. en is not latched;
//     the producer must assert en again.
//  Data stability:
//   - patch_out is driven directly from the capture buffer.
//   - In PROCESSING it holds partial data; consumers must qualify it with out_valid.
//   - In DONE it is stable until output_taken.
//  Width rules: pixel_count reaches PATCH_VECTOR_SIZE, then freezes until cleared.
//   row and col never exceed PATCH_SIZE-1.
// CONFIGURATION
//  PATCH_REASSEMBLER_COLMAJOR_EN
//   - Defined: the stream is column-major. Index k maps to patch_out[k%PATCH_SIZE][k/PATCH_SIZE];
//     row increments first and col increments on row wrap.
//   - Undefined (default): the stream is row-major. Index k maps to
//     patch_out[k/PATCH_SIZE][k%PATCH_SIZE], matching the patchifier's output order.
//   - All handshake, timing and reset behaviour is identical in both builds.
// TESTING (PATCH_SIZE=8 unless noted)
//  1. Pulse en, stream pixels k=0..63 back-to-back with value k.
//     -> patch_out[r][c]=r*8+c; state=DONE and out_valid=1 exactly one cycle after the 64th
//        accept; pixel_count=64.
//  2. Same stream with in_valid toggling 1,0,0,1,...
//     -> identical final patch; in_ready high throughout PROCESSING; no pixel dropped or duplicated.
//  3. In DONE, hold output_taken=0 for 10 cycles, then pulse it.
//     -> patch_out stable over the 10 cycles; next cycle state=IDLE, out_valid=0,
//        all elements 0, pixel_count=0.
//  4. Assert reset after 30 accepts.
//     -> next cycle state=IDLE, pixel_count=0, patch_out all 0. A new 64-pixel patch then
//        assembles correctly.
//  5. Pulse en in DONE, and en together with output_taken.
//     -> DONE is held until output_taken; after the simultaneous case state=IDLE and
//        no capture starts.
//  6. Build with PATCH_REASSEMBLER_COLMAJOR_EN, stream k=0..63.
//     -> patch_out[r][c]=c*8+r.

Source files
------------

// File: rtl/patch_reassembler.sv
// Rebuilds a PATCH_SIZE x PATCH_SIZE patch from a serial valid/ready pixel stream and holds it until consumed.
// Build option: PATCH_REASSEMBLER_COLMAJOR_EN selects a column-major stream (default is row-major).
module patch_reassembler #(
  parameter int CHANNEL_SIZE      = 8,
  parameter int NUM_CHANNELS      = 3,
  parameter int PIXEL_WIDTH       = CHANNEL_SIZE * NUM_CHANNELS,
  parameter int PATCH_SIZE        = 16,
  parameter int PATCH_VECTOR_SIZE = PATCH_SIZE * PATCH_SIZE,
  parameter int CNT_W             = $clog2(PATCH_VECTOR_SIZE + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [PIXEL_WIDTH-1:0] in_pixel,
  output logic                   in_ready,
  input  logic                   output_taken,
  output logic [1:0]             state,
  output logic                   out_valid,
  output logic [CNT_W-1:0]       pixel_count,
  output logic [PATCH_SIZE-1:0][PATCH_SIZE-1:0][PIXEL_WIDTH-1:0] patch_out
);

  localparam int IDX_W = $clog2(PATCH_SIZE);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(PATCH_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PATCH_VECTOR_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    PROCESSING = 2'b01,
    DONE       = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PATCH_SIZE-1:0][PATCH_SIZE-1:0][PIXEL_WIDTH-1:0] buf_q;

  logic accept;
  logic take;
  logic last_accept;

  assign accept      = in_valid && (state_q == PROCESSING);
  assign take        = output_taken && (state_q == DONE);
  assign last_accept = accept && (count_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (en)           state_d = PROCESSING;
      PROCESSING: if (last_accept)  state_d = DONE;
      DONE:       if (output_taken) state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == PROCESSING);
    out_valid   = (state_q == DONE);
    state       = state_q;
    pixel_count = count_q;
    patch_out   = buf_q;
  end

  // Write pointer: the fast index wraps at PATCH_SIZE-1 and bumps the slow index.
  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    count_d = count_q;
    if (take) begin
      row_d   = '0;
      col_d   = '0;
      count_d = '0;
    end else if (accept) begin
      count_d = count_q + 1'b1;
`ifdef PATCH_REASSEMBLER_COLMAJOR_EN
      if (row_q == IDX_MAX) begin
        row_d = '0;
        col_d = (col_q == IDX_MAX) ? '0 : col_q + 1'b1;
      end else begin
        row_d = row_q + 1'b1;
      end
`else
      if (col_q == IDX_MAX) begin
        col_d = '0;
        row_d = (row_q == IDX_MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q <= '0;
    end else if (take) begin
      buf_q <= '0;
    end else if (accept) begin
      buf_q[row_q][col_q] <= in_pixel;
    end
  end

endmodule
